// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, default
// long-opcode marker and default fetch timeout, plus small helper functions.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_ISSUE_HI = 3'd3,
    S_ISSUE_LO = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  localparam logic [3:0] LONG_OPC_DEF = 4'hF;
  localparam int         TIMEOUT_DEF  = 15;

  // Counter width able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic is_long(input logic [15:0] word, input logic [3:0] opc);
    return (word[15:12] == opc);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory and datapath handshake bundle of the fetch sequencer.
//   master (sequencer): drives mem_read, ir_load, pc_inc, issue, issue_half,
//                       issue_long; samples mem_ready, ir_word, exec_done, flush.
//   slave  (memory/datapath side): the mirror image.
interface fetch_sequencer_if;
  logic        mem_read;
  logic        mem_ready;
  logic [15:0] ir_word;
  logic        ir_load;
  logic        pc_inc;
  logic        issue;
  logic        issue_half;
  logic        issue_long;
  logic        exec_done;
  logic        flush;

  modport master (
    output mem_read, ir_load, pc_inc, issue, issue_half, issue_long,
    input  mem_ready, ir_word, exec_done, flush
  );

  modport slave (
    input  mem_read, ir_load, pc_inc, issue, issue_half, issue_long,
    output mem_ready, ir_word, exec_done, flush
  );
endinterface

// File: rtl/fetch_sequencer_timer.sv
// fetch_timer: counts FETCH cycles spent waiting for mem_ready.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : hold the count at zero (asserted whenever not fetching)
//   enable_i    : one waiting cycle elapses this cycle
//   expired_o   : this waiting cycle is the TIMEOUT-th one
module fetch_timer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && (cnt_q != SAT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Flag expiry during the waiting cycle that brings the count to TIMEOUT,
  // so the FSM leaves FETCH after exactly TIMEOUT waiting cycles.
  assign expired_o = enable_i && !clear_i && (cnt_q >= LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 16-bit instruction words and issues them to the
// datapath as one long instruction or as an upper/lower byte pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   go_i       : leave IDLE and start fetching
//   halt_i     : return to IDLE at the next instruction boundary
//   err_o      : sticky fetch-timeout flag (cleared only by reset)
//   bus        : memory/datapath handshake (master side)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [3:0] LONG_OPC = LONG_OPC_DEF,
  parameter int         TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go_i,
  input  logic                halt_i,
  output logic                err_o,
  fetch_sequencer_if.master   bus
);

  state_t state_q, state_d;
  logic   long_q, long_d;
  logic   expired;

  logic mem_read, ir_load, pc_inc, issue, issue_half, issue_long, err;

  // Counter is held clear outside FETCH, so it starts from zero on every entry.
  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q != S_FETCH),
    .enable_i  ((state_q == S_FETCH) && !bus.mem_ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    long_d     = long_q;
    mem_read   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    issue      = 1'b0;
    issue_half = 1'b0;
    issue_long = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        ir_load  = bus.mem_ready;
        // A word arriving wins over halt: once loaded it must be issued.
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (halt_i)    state_d = S_IDLE;
        else if (expired)   state_d = S_ERR;
      end
      S_DECODE: begin
        long_d  = is_long(bus.ir_word, LONG_OPC);
        state_d = S_ISSUE_HI;
      end
      S_ISSUE_HI: begin
        issue      = 1'b1;
        issue_long = long_q;
        if (bus.exec_done) begin
          // Long words and taken jumps end the word here; otherwise the
          // lower byte still has to be issued from the same word.
          if (long_q || bus.flush) begin
            pc_inc  = 1'b1;
            state_d = halt_i ? S_IDLE : S_FETCH;
          end else begin
            state_d = S_ISSUE_LO;
          end
        end
      end
      S_ISSUE_LO: begin
        issue      = 1'b1;
        issue_half = 1'b1;
        if (bus.exec_done) begin
          pc_inc  = 1'b1;
          state_d = halt_i ? S_IDLE : S_FETCH;
        end
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      long_q  <= long_d;
    end
  end

  assign bus.mem_read   = mem_read;
  assign bus.ir_load    = ir_load;
  assign bus.pc_inc     = pc_inc;
  assign bus.issue      = issue;
  assign bus.issue_half = issue_half;
  assign bus.issue_long = issue_long;
  assign err_o          = err;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n, go, halt, err;

  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.LONG_OPC(4'hF), .TIMEOUT(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .go_i   (go),
    .halt_i (halt),
    .err_o  (err),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int pc_cnt      = 0;
  int pc_base;

  typedef struct packed {logic half; logic lng;} iss_t;
  iss_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [6:0] outs();
    return {bus.mem_read, bus.ir_load, bus.pc_inc, bus.issue,
            bus.issue_half, bus.issue_long, err};
  endfunction

  // Scoreboard: each accepted instruction (issue && exec_done at an edge)
  // is matched against the next expected issue record.
  always @(posedge clk) begin
    if (bus.pc_inc) pc_cnt++;
    if (bus.issue && bus.exec_done) begin
      iss_t e;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_issue_half", {31'd0, bus.issue_half}, {31'd0, e.half});
        check("sb_issue_long", {31'd0, bus.issue_long}, {31'd0, e.lng});
      end
    end
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; halt = 1'b0;
    bus.mem_ready = 1'b0; bus.ir_word = 16'h0000;
    bus.exec_done = 1'b0; bus.flush = 1'b0;
    #1;
    check("reset_outs", {25'd0, outs()}, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    check("idle_no_go", {25'd0, outs()}, 32'd0);

    // Short pair 16'h1234
    go = 1'b1;
    tick; go = 1'b0;
    check("fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
    check("fetch_no_ir_load", {31'd0, bus.ir_load}, 32'd0);
    tick;
    pc_base = pc_cnt;
    bus.mem_ready = 1'b1; bus.ir_word = 16'h1234;
    exp_q.push_back('{half: 1'b0, lng: 1'b0});
    exp_q.push_back('{half: 1'b1, lng: 1'b0});
    #1;
    check("fetch_ir_load", {31'd0, bus.ir_load}, 32'd1);
    tick; bus.mem_ready = 1'b0;
    check("decode_quiet", {25'd0, outs()}, 32'd0);
    tick;
    check("latency_issue", {31'd0, bus.issue}, 32'd1);
    check("short_hi_half", {31'd0, bus.issue_half}, 32'd0);
    bus.exec_done = 1'b1; #1;
    check("short_hi_no_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
    tick; bus.exec_done = 1'b0;
    check("short_lo_half", {30'd0, bus.issue, bus.issue_half}, 32'd3);
    tick;
    check("short_lo_hold", {31'd0, bus.issue}, 32'd1);
    bus.exec_done = 1'b1; #1;
    check("short_lo_pc_inc", {31'd0, bus.pc_inc}, 32'd1);
    tick; bus.exec_done = 1'b0;
    check("short_back_fetch", {31'd0, bus.mem_read}, 32'd1);
    check("short_pc_inc_count", pc_cnt - pc_base, 32'd1);

    // Long word 16'hF0AB
    pc_base = pc_cnt;
    bus.mem_ready = 1'b1; bus.ir_word = 16'hF0AB;
    exp_q.push_back('{half: 1'b0, lng: 1'b1});
    tick; bus.mem_ready = 1'b0;
    tick;
    check("long_issue_long", {30'd0, bus.issue, bus.issue_long}, 32'd3);
    bus.exec_done = 1'b1; #1;
    check("long_pc_inc", {31'd0, bus.pc_inc}, 32'd1);
    tick; bus.exec_done = 1'b0;
    check("long_no_issue_lo", {30'd0, bus.issue, bus.mem_read}, 32'd1);
    check("long_pc_inc_count", pc_cnt - pc_base, 32'd1);

    // Flush on short word 16'h2345
    bus.mem_ready = 1'b1; bus.ir_word = 16'h2345;
    exp_q.push_back('{half: 1'b0, lng: 1'b0});
    tick; bus.mem_ready = 1'b0;
    tick;
    bus.exec_done = 1'b1; bus.flush = 1'b1; #1;
    check("flush_pc_inc", {31'd0, bus.pc_inc}, 32'd1);
    tick; bus.exec_done = 1'b0; bus.flush = 1'b0;
    check("flush_skip_lo", {30'd0, bus.issue, bus.mem_read}, 32'd1);

    // exec_done and go in FETCH are ignored
    bus.exec_done = 1'b1; go = 1'b1; #1;
    check("fetch_exec_done_ign", {31'd0, bus.pc_inc}, 32'd0);
    tick; bus.exec_done = 1'b0; go = 1'b0;
    check("fetch_stays", {30'd0, bus.issue, bus.mem_read}, 32'd1);

    // Halt during ISSUE_LO, 16'h1111
    bus.mem_ready = 1'b1; bus.ir_word = 16'h1111;
    exp_q.push_back('{half: 1'b0, lng: 1'b0});
    exp_q.push_back('{half: 1'b1, lng: 1'b0});
    tick; bus.mem_ready = 1'b0;
    tick; bus.exec_done = 1'b1;
    tick; bus.exec_done = 1'b0; halt = 1'b1;
    tick;
    check("halt_not_abandon", {30'd0, bus.issue, bus.issue_half}, 32'd3);
    bus.exec_done = 1'b1; #1;
    check("halt_pc_inc", {31'd0, bus.pc_inc}, 32'd1);
    tick; bus.exec_done = 1'b0;
    check("halt_idle", {25'd0, outs()}, 32'd0);
    halt = 1'b0;
    tick;
    check("halt_stay_idle", {31'd0, bus.mem_read}, 32'd0);
    go = 1'b1;
    tick; go = 1'b0;
    check("resume_fetch", {31'd0, bus.mem_read}, 32'd1);

    // Halt in FETCH before mem_ready
    halt = 1'b1; #1;
    check("halt_fetch_no_load", {31'd0, bus.ir_load}, 32'd0);
    tick; halt = 1'b0;
    check("halt_fetch_idle", {31'd0, bus.mem_read}, 32'd0);
    go = 1'b1;
    tick; go = 1'b0;

    // Timeout: 15 FETCH cycles without mem_ready
    repeat (14) tick;
    check("timeout_not_yet", {30'd0, bus.mem_read, err}, 32'd2);
    tick;
    check("timeout_err", {30'd0, bus.mem_read, err}, 32'd1);
    go = 1'b1; bus.mem_ready = 1'b1;
    repeat (3) tick;
    check("err_sticky", {25'd0, outs()}, 32'd1);
    go = 1'b0; bus.mem_ready = 1'b0;
    rst_n = 1'b0; #1;
    check("err_cleared_by_reset", {31'd0, err}, 32'd0);
    tick; rst_n = 1'b1;
    tick;
    check("post_reset_idle", {25'd0, outs()}, 32'd0);

    // Reset mid-fetch
    go = 1'b1;
    tick; go = 1'b0;
    bus.mem_ready = 1'b1; #1;
    check("midfetch_active", {30'd0, bus.mem_read, bus.ir_load}, 32'd3);
    rst_n = 1'b0; #1;
    check("midfetch_async_reset", {25'd0, outs()}, 32'd0);
    bus.mem_ready = 1'b0;
    tick; rst_n = 1'b1;
    tick;
    check("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter LONG_OPC, default 4'hF: value of ir_word[15:12] that marks a 16-bit (long) instruction.
REQ-002 Parameter TIMEOUT, default 15: maximum number of FETCH cycles without mem_ready before the error state is entered.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 go  in  1  level; leave IDLE and start fetching.
REQ-006 halt  in  1  level; return to IDLE at the next instruction boundary.
REQ-007 mem_ready  in  1  memory read data is valid on the bus this cycle.
REQ-008 ir_word  in  16  current contents of the instruction register.
REQ-009 exec_done  in  1  one-cycle pulse; the datapath has finished the issued instruction.
REQ-010 flush  in  1  sampled with exec_done; a taken jump or branch discards the low half.
REQ-011 mem_read  out  1  memory read request.
REQ-012 ir_load  out  1  instruction-register load enable.
REQ-013 pc_inc  out  1  one-cycle pulse that advances the PC by one word.
REQ-014 issue  out  1  an instruction is presented to the datapath.
REQ-015 issue_half  out  1  0 = upper byte (or long word), 1 = lower byte.
REQ-016 issue_long  out  1  the issued instruction is 16-bit.
REQ-017 err  out  1  sticky fetch-timeout flag.

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, DECODE, ISSUE_HI, ISSUE_LO and ERR.
REQ-019 IDLE: all outputs SHALL be 0 except err; go=1 SHALL move the block to FETCH on the next edge.
REQ-020 FETCH: mem_read SHALL be 1; ir_load SHALL equal mem_ready (combinational), so the IR captures on the same edge; mem_ready=1 SHALL move the block to DECODE.
REQ-021 FETCH timeout: a counter SHALL clear on entry to FETCH and increment each cycle without mem_ready; when it reaches TIMEOUT the block SHALL go to ERR. The counter is wide enough for TIMEOUT and saturates.
REQ-022 DECODE: one cycle, no outputs; SHALL register long = (ir_word[15:12]==LONG_OPC) and then go to ISSUE_HI.
REQ-023 ISSUE_HI: issue=1, issue_half=0, issue_long=long; the block SHALL hold until exec_done.
REQ-024 On exec_done in ISSUE_HI, when long=1 or flush=1: pc_inc SHALL pulse in that cycle; next state SHALL be IDLE if halt=1, else FETCH.
REQ-025 On exec_done in ISSUE_HI, when long=0 and flush=0: next state SHALL be ISSUE_LO, with no pc_inc.
REQ-026 ISSUE_LO: issue=1, issue_half=1, issue_long=0; on exec_done pc_inc SHALL pulse and the next state follows REQ-024. flush has no further effect in this state.
REQ-027 halt SHALL be honoured only at exec_done boundaries or in FETCH before mem_ready (FETCH->IDLE, no ir_load). An instruction that is already issued SHALL never be abandoned.
REQ-028 exec_done outside ISSUE_HI or ISSUE_LO SHALL be ignored.
REQ-029 ERR: err=1 (sticky) and all other outputs 0; the block SHALL leave ERR only through reset.
REQ-030 go while not in IDLE SHALL be ignored.
REQ-031 Latency: mem_ready to issue SHALL be exactly 2 edges (FETCH->DECODE->ISSUE_HI).

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, counter 0, long 0 and every output 0 (including err), even mid-fetch or mid-issue.
REQ-033 After rst_n is released, the block SHALL stay in IDLE until go is sampled at 1.

Structure
REQ-034 A shared package SHALL hold the state encoding, the LONG_OPC default and the TIMEOUT default.
REQ-035 The timeout counter SHALL be one sub-module, fetch_timer (clear, enable, expired).
REQ-036 The state register SHALL be sequential logic with an asynchronous reset; next-state and output logic SHALL be combinational.

Verification
REQ-037 Short pair: go=1, mem_ready after 2 cycles with word 16'h1234, exec_done twice -> issue_half 0 then 1, issue_long=0, exactly one pc_inc, then back in FETCH.
REQ-038 Long: word 16'hF0AB, exec_done once -> issue_long=1, pc_inc on that exec_done, no ISSUE_LO.
REQ-039 Flush: word 16'h2345, exec_done with flush=1 in ISSUE_HI -> pc_inc, ISSUE_LO skipped, mem_read=1 on the next cycle.
REQ-040 Timeout: mem_ready held at 0 for 15 FETCH cycles -> err=1 sticky, mem_read=0; only rst_n=0 clears err.
REQ-041 Halt: halt=1 during ISSUE_LO, then exec_done -> pc_inc, IDLE, no mem_read; go=1 resumes fetching.
REQ-042 Reset mid-fetch: rst_n=0 while mem_read=1 -> all outputs 0 immediately, without waiting for a clock edge.
